// File: rtl/comb_stim_checker.sv
// ---------------------------------------------------------------------------
// comb_stim_checker
//
// Drives a golden and a fault-injected registered wrapper with the same
// pseudo-random stimulus, compares their responses LAT edges after each
// vector is launched, counts mismatching vectors and records the first one.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             1-cycle pulse, accepted only in IDLE or DONE
//   num_vec           vectors per run, sampled on the accepted start
//   dut_in            stimulus to both wrappers (bit 0 -> in[0])
//   gold_out          golden wrapper response
//   fault_out         fault-injected wrapper response
//   busy              high while issuing (RUN) or draining (DRAIN)
//   done              high in DONE until the next accepted start
//   err_count         mismatching vectors this run, saturating
//   first_err_vld     at least one mismatch seen this run
//   first_err_idx     0-based index of the first mismatching vector
//   first_err_xor     gold_out ^ fault_out of the first mismatch
//   misr_sig          (STIM_MISR_EN only) signature of fault_out over
//                     every checked cycle
//
// Optional feature macro: STIM_MISR_EN
// ---------------------------------------------------------------------------
module comb_stim_checker #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 7,
  parameter int LAT   = 2,
  parameter int CNT_W = 32,
  parameter logic [IN_W-1:0] SEED = IN_W'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] gold_out,
  input  logic [OUT_W-1:0] fault_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_vld,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [OUT_W-1:0] first_err_xor
`ifdef STIM_MISR_EN
  ,
  output logic [31:0]      misr_sig
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DW = $clog2(LAT + 1);
  // A zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
  // Galois taps for x^36 + x^25 + 1 (bits 25 and 0).
  localparam logic [IN_W-1:0] TAPS = IN_W'(36'h0_0200_0001);

  state_t state, state_nxt;

  logic [IN_W-1:0]  lfsr;
  logic [IN_W-1:0]  lfsr_nxt;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] num_q;
  logic [DW-1:0]    drain_cnt;
  logic [LAT-1:0]   vd;
  logic [CNT_W-1:0] idx_pipe [LAT];

  logic start_acc;
  logic issue;
  logic run_last;
  logic drain_last;
  logic chk_vld;
  logic mismatch;

`ifdef STIM_MISR_EN
  logic [31:0] misr_q;
  assign misr_sig = misr_q;
`endif

  assign start_acc  = start && ((state == IDLE) || (state == DONE));
  assign issue      = (state == RUN) && (num_q != '0);
  // With num_vec == 0 RUN still lasts one cycle but launches nothing.
  assign run_last   = (num_q == '0) || (vec_cnt == num_q - CNT_W'(1));
  assign drain_last = (drain_cnt == DW'(LAT - 1));
  // The tail of the valid line marks the cycle in which the vector launched
  // LAT edges earlier has its response on gold_out/fault_out.
  assign chk_vld    = vd[LAT-1];
  assign mismatch   = (gold_out != fault_out);
  assign lfsr_nxt   = {lfsr[IN_W-2:0], 1'b0} ^ (lfsr[IN_W-1] ? TAPS : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A start that coincides with the DRAIN->DONE step is dropped because
  // start_acc only looks at IDLE and DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc)  state_nxt = RUN;
      RUN:     if (run_last)   state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = DONE;
      DONE:    if (start_acc)  state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, DRAIN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // The index pipeline travels with the valid line so the recorded index is
  // the vector actually being checked, not the one currently being issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in        <= '0;
      lfsr          <= SEED_EFF;
      vec_cnt       <= '0;
      num_q         <= '0;
      drain_cnt     <= '0;
      vd            <= '0;
      for (int i = 0; i < LAT; i++) idx_pipe[i] <= '0;
      err_count     <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      first_err_xor <= '0;
`ifdef STIM_MISR_EN
      misr_q        <= '0;
`endif
    end else begin
      vd[0]       <= issue;
      idx_pipe[0] <= vec_cnt;
      for (int i = 1; i < LAT; i++) begin
        vd[i]       <= vd[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;

      if (start_acc) begin
        lfsr          <= SEED_EFF;
        vec_cnt       <= '0;
        num_q         <= num_vec;
        err_count     <= '0;
        first_err_vld <= 1'b0;
        first_err_idx <= '0;
        first_err_xor <= '0;
`ifdef STIM_MISR_EN
        misr_q        <= '0;
`endif
      end else begin
        if (issue) begin
          dut_in  <= lfsr;
          lfsr    <= lfsr_nxt;
          vec_cnt <= vec_cnt + CNT_W'(1);
        end
        if (chk_vld && mismatch) begin
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
          if (!first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= idx_pipe[LAT-1];
            first_err_xor <= gold_out ^ fault_out;
          end
        end
`ifdef STIM_MISR_EN
        if (chk_vld) begin
          misr_q <= {misr_q[30:0], ^(misr_q & 32'h8020_0003)}
                    ^ {{(32-OUT_W){1'b0}}, fault_out};
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_comb_stim_checker.sv
// ---------------------------------------------------------------------------
// tb_comb_stim_checker
//
// Bench for comb_stim_checker. A small wrapper model (input register plus
// combinational logic) produces gold_out; fault_out is gold_out with chosen
// bits flipped whenever the wrapper holds a selected vector. Table rows cover
// the main run variants; hand sequences cover reset, ignored starts and the
// seed/first-vector behaviour.
// ---------------------------------------------------------------------------
module tb_comb_stim_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] num_vec;
  logic [35:0] din, din0;
  logic [6:0]  gold_out, fault_out;
  logic        busy, done, busy0, done0;
  logic [31:0] err, err0, idx, idx0;
  logic        vld, vld0;
  logic [6:0]  xorv, xor0;
`ifdef STIM_MISR_EN
  logic [31:0] misr, misr0;
`endif

  // Wrapper model and fault injection controls
  logic [35:0] in_q;
  logic [35:0] fval_a, fval_b;
  logic [6:0]  fmask_a, fmask_b;
  logic        zero_fault;

  int compared;
  int mismatched;

  comb_stim_checker #(.SEED(36'h1)) dut (
`ifdef STIM_MISR_EN
    .misr_sig(misr),
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .dut_in(din), .gold_out(gold_out), .fault_out(fault_out),
    .busy(busy), .done(done), .err_count(err), .first_err_vld(vld),
    .first_err_idx(idx), .first_err_xor(xorv)
  );

  comb_stim_checker #(.SEED(36'h0)) dut0 (
`ifdef STIM_MISR_EN
    .misr_sig(misr0),
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .dut_in(din0), .gold_out(gold_out), .fault_out(fault_out),
    .busy(busy0), .done(done0), .err_count(err0), .first_err_vld(vld0),
    .first_err_idx(idx0), .first_err_xor(xor0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] wrap_f(input logic [35:0] x);
    return x[6:0] ^ x[35:29] ^ x[22:16];
  endfunction

  // Vector k of a run from seed 1 (x^36 + x^25 + 1, Galois, shifting left).
  function automatic logic [35:0] lfsr_at(input int k);
    logic [35:0] x;
    x = 36'h1;
    for (int i = 0; i < k; i++)
      x = {x[34:0], 1'b0} ^ (x[35] ? 36'h0_0200_0001 : 36'h0);
    return x;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= '0;
    else        in_q <= din;
  end

  assign gold_out  = wrap_f(in_q);
  assign fault_out = zero_fault ? 7'h00 :
                     (gold_out ^ ((in_q == fval_a) ? fmask_a : 7'h00)
                               ^ ((in_q == fval_b) ? fmask_b : 7'h00));

  typedef struct {
    int unsigned num;
    int          fidx_a;
    logic [6:0]  fmask_a;
    int          fidx_b;
    logic [6:0]  fmask_b;
    int unsigned exp_err;
    bit          exp_vld;
    int unsigned exp_idx;
    logic [6:0]  exp_xor;
  } vec_t;

  vec_t tbl [6];

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Launches one run from a negedge; returns at the first negedge with done
  // high (or after the cycle budget), counting busy cycles on the way.
  task automatic applyStimulus(input vec_t v, output int busy_cyc,
                               output bit ok);
    fval_a  = lfsr_at(v.fidx_a);
    fmask_a = v.fmask_a;
    fval_b  = lfsr_at(v.fidx_b);
    fmask_b = v.fmask_b;
    num_vec = v.num;
    start   = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    busy_cyc = 0;
    ok       = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int          bc;
    bit          ok;
    logic [35:0] prev_din;
    logic [35:0] exp_din;
    vec_t        v;

    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    num_vec    = '0;
    zero_fault = 1'b0;
    fval_a     = '0;
    fval_b     = '0;
    fmask_a    = '0;
    fmask_b    = '0;

    tbl[0] = '{16,  0, 7'h00,  0, 7'h00, 0, 1'b0,  0, 7'h00};
    tbl[1] = '{100, 37, 7'h01, 0, 7'h00, 1, 1'b1, 37, 7'h01};
    tbl[2] = '{8,   3, 7'h10,  5, 7'h06, 2, 1'b1,  3, 7'h10};
    tbl[3] = '{8,   0, 7'h7F,  7, 7'h40, 2, 1'b1,  0, 7'h7F};
    tbl[4] = '{1,   0, 7'h22,  0, 7'h00, 1, 1'b1,  0, 7'h22};
    tbl[5] = '{0,   0, 7'h00,  0, 7'h00, 0, 1'b0,  0, 7'h00};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset busy",   64'(busy), 64'(0));
    checkOutput("reset done",   64'(done), 64'(0));
    checkOutput("reset dut_in", 64'(din),  64'(0));
    checkOutput("reset err",    64'(err),  64'(0));
    checkOutput("reset vld",    64'(vld),  64'(0));
    @(negedge clk);

    // First vectors from SEED=1 and SEED=0 are 1 then 2; all-zero fault_out
    // makes every one of the 4 vectors mismatch.
    zero_fault = 1'b1;
    num_vec    = 4;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("seed0 first dut_in", 64'(din0), 64'(36'h1));
    checkOutput("seed1 first dut_in", 64'(din),  64'(36'h1));
    @(negedge clk);
    checkOutput("seed0 second dut_in", 64'(din0), 64'(36'h2));
    checkOutput("seed1 second dut_in", 64'(din),  64'(36'h2));
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("zero-fault run done", 64'(ok),   64'(1));
    checkOutput("zero-fault err",      64'(err),  64'(4));
    checkOutput("zero-fault idx",      64'(idx),  64'(0));
    checkOutput("zero-fault xor",      64'(xorv), 64'(7'h01));
`ifdef STIM_MISR_EN
    checkOutput("zero-fault misr", 64'(misr), 64'(0));
`endif
    zero_fault = 1'b0;
    prev_din   = lfsr_at(3);

    for (int r = 0; r < 6; r++) begin
      applyStimulus(tbl[r], bc, ok);
      exp_din = (tbl[r].num == 0) ? prev_din : lfsr_at(int'(tbl[r].num) - 1);
      checkOutput($sformatf("row%0d done reached", r), 64'(ok), 64'(1));
      checkOutput($sformatf("row%0d busy cycles", r), 64'(bc),
                  64'((tbl[r].num == 0) ? 3 : tbl[r].num + 2));
      checkOutput($sformatf("row%0d err_count", r), 64'(err),
                  64'(tbl[r].exp_err));
      checkOutput($sformatf("row%0d first_err_vld", r), 64'(vld),
                  64'(tbl[r].exp_vld));
      checkOutput($sformatf("row%0d first_err_idx", r), 64'(idx),
                  64'(tbl[r].exp_idx));
      checkOutput($sformatf("row%0d first_err_xor", r), 64'(xorv),
                  64'(tbl[r].exp_xor));
      checkOutput($sformatf("row%0d dut_in", r), 64'(din), 64'(exp_din));
      checkOutput($sformatf("row%0d seed0 dut_in", r), 64'(din0),
                  64'(exp_din));
      prev_din = exp_din;
      @(negedge clk);
    end

    // start during RUN and on the DRAIN->DONE edge must both be ignored.
    fval_a  = lfsr_at(4);
    fmask_a = 7'h08;
    fmask_b = 7'h00;
    num_vec = 10;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mid-run start busy", 64'(busy), 64'(1));
    repeat (8) @(negedge clk);
    checkOutput("last drain busy", 64'(busy), 64'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done-entry start done", 64'(done), 64'(1));
    checkOutput("done-entry start busy", 64'(busy), 64'(0));
    @(negedge clk);
    checkOutput("dropped start done", 64'(done), 64'(1));
    checkOutput("dropped start busy", 64'(busy), 64'(0));
    checkOutput("dropped start err",  64'(err),  64'(1));
    checkOutput("dropped start idx",  64'(idx),  64'(4));
    checkOutput("dropped start xor",  64'(xorv), 64'(7'h08));
    checkOutput("dropped start dut_in", 64'(din), 64'(lfsr_at(9)));

    // Reset in the middle of a run that has already logged an error.
    fval_a  = lfsr_at(2);
    fmask_a = 7'h05;
    num_vec = 50;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("pre-reset err",  64'(err),  64'(1));
    checkOutput("pre-reset busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset busy",   64'(busy), 64'(0));
    checkOutput("async reset done",   64'(done), 64'(0));
    checkOutput("async reset err",    64'(err),  64'(0));
    checkOutput("async reset vld",    64'(vld),  64'(0));
    checkOutput("async reset idx",    64'(idx),  64'(0));
    checkOutput("async reset xor",    64'(xorv), 64'(0));
    checkOutput("async reset dut_in", 64'(din),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post-reset idle busy", 64'(busy), 64'(0));
    checkOutput("post-reset idle done", 64'(done), 64'(0));
    checkOutput("post-reset dut_in",    64'(din),  64'(0));

    v = '{3, 0, 7'h00, 0, 7'h00, 0, 1'b0, 0, 7'h00};
    fmask_a = 7'h00;
    applyStimulus(v, bc, ok);
    checkOutput("recovery done",   64'(ok),  64'(1));
    checkOutput("recovery busy",   64'(bc),  64'(5));
    checkOutput("recovery err",    64'(err), 64'(0));
    checkOutput("recovery dut_in", 64'(din), 64'(36'h4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
